// File: rtl/ps2_device_tx.sv
// PS/2 device-side transmitter: a byte FIFO feeds an FSM that serialises
// 11-bit frames (start, 8 data LSB first, odd parity, stop) onto registered
// ps2_clk/ps2_data lines. Host inhibit aborts a frame before the stop slot;
// the head byte stays queued until its frame completes, so it is resent.
module ps2_device_tx #(
    parameter int unsigned HALF_PERIOD = 8,
    parameter int unsigned GAP_CYCLES  = 32,
    parameter int unsigned FIFO_DEPTH  = 8
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [7:0]                    in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          host_inhibit,
    output logic                          ps2_clk,
    output logic                          ps2_data,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned PH_W  = $clog2(2 * HALF_PERIOD);
    localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);

    localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(2 * HALF_PERIOD - 1);
    localparam logic [PH_W-1:0]  PH_HALF   = PH_W'(HALF_PERIOD);
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
    localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_INHIB,
        ST_GAP
    } state_t;

    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    state_t           r_state;
    logic [3:0]       r_bit_idx;
    logic [PH_W-1:0]  r_phase;
    logic [GAP_W-1:0] r_gap;
    logic             r_ps2_clk;
    logic             r_ps2_data;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic [7:0]       w_head;
    logic [10:0]      w_frame;

    assign w_full  = (r_count == DEPTH_CNT);
    assign w_empty = (r_count == '0);
    assign w_push  = in_valid && !w_full;
    // Pop only when the stop-bit slot has fully elapsed.
    assign w_pop   = (r_state == ST_SEND) && (r_bit_idx == 4'd10) && (r_phase == PH_LAST);
    assign w_head  = r_mem[r_rd_ptr];
    assign w_frame = {1'b1, ~^w_head, w_head, 1'b0};

    assign in_ready   = !w_full;
    assign busy       = !w_empty || (r_state != ST_IDLE);
    assign fifo_count = r_count;
    assign ps2_clk    = r_ps2_clk;
    assign ps2_data   = r_ps2_data;

    // FIFO storage write (no reset needed on the data array).
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
                2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Frame FSM; line outputs are registered and trail the slot counters by one cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= ST_IDLE;
            r_bit_idx  <= '0;
            r_phase    <= '0;
            r_gap      <= '0;
            r_ps2_clk  <= 1'b1;
            r_ps2_data <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_ps2_clk  <= 1'b1;
                    r_ps2_data <= 1'b1;
                    if (!w_empty && !host_inhibit) begin
                        r_state   <= ST_SEND;
                        r_bit_idx <= '0;
                        r_phase   <= '0;
                    end
                end
                ST_SEND: begin
                    if (host_inhibit && (r_bit_idx <= 4'd9)) begin
                        r_state    <= ST_INHIB;
                        r_bit_idx  <= '0;
                        r_phase    <= '0;
                        r_ps2_clk  <= 1'b1;
                        r_ps2_data <= 1'b1;
                    end else begin
                        r_ps2_data <= w_frame[r_bit_idx];
                        r_ps2_clk  <= (r_phase < PH_HALF);
                        if (r_phase == PH_LAST) begin
                            r_phase <= '0;
                            if (r_bit_idx == 4'd10) begin
                                r_state   <= ST_GAP;
                                r_bit_idx <= '0;
                                r_gap     <= '0;
                            end else begin
                                r_bit_idx <= r_bit_idx + 4'd1;
                            end
                        end else begin
                            r_phase <= r_phase + PH_W'(1);
                        end
                    end
                end
                ST_INHIB: begin
                    r_ps2_clk  <= 1'b1;
                    r_ps2_data <= 1'b1;
                    if (!host_inhibit) begin
                        r_state <= ST_GAP;
                        r_gap   <= '0;
                    end
                end
                ST_GAP: begin
                    r_ps2_clk  <= 1'b1;
                    r_ps2_data <= 1'b1;
                    if (r_gap == GAP_LAST) begin
                        r_state <= ST_IDLE;
                        r_gap   <= '0;
                    end else begin
                        r_gap <= r_gap + GAP_W'(1);
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_ps2_clk  <= 1'b1;
                    r_ps2_data <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_device_tx.sv
// Directed bench for ps2_device_tx: a host-side receiver model samples
// ps2_data on each ps2_clk falling edge and collects completed frames.
module tb_ps2_device_tx;

    localparam int unsigned HP    = 4;
    localparam int unsigned GAP   = 8;
    localparam int unsigned DEPTH = 8;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       host_inhibit = 1'b0;
    logic       ps2_clk;
    logic       ps2_data;
    logic       busy;
    logic [3:0] fifo_count;

    int n_tests = 0;
    int n_fail  = 0;

    int unsigned cyc = 0;
    logic [7:0]  rx_q[$];
    logic        par_q[$];
    logic        bits_q[$];
    int unsigned start_q[$];
    int          rx_bitcnt = 0;
    int          frame_err = 0;

    ps2_device_tx #(
        .HALF_PERIOD(HP),
        .GAP_CYCLES (GAP),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .host_inhibit(host_inhibit),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .busy        (busy),
        .fifo_count  (fifo_count)
    );

    always #5 clk = ~clk;

    // Cycle counter for frame spacing measurements.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Host receiver model: falling-edge sampling, long clock-high resets a partial frame.
    initial begin
        logic        prev_clk;
        logic [10:0] frame;
        int          hi_cnt;
        prev_clk = 1'b1;
        frame    = '0;
        hi_cnt   = 0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                rx_bitcnt = 0;
                hi_cnt    = 0;
            end else if (prev_clk && !ps2_clk) begin
                if (rx_bitcnt == 0) start_q.push_back(cyc);
                frame[rx_bitcnt] = ps2_data;
                bits_q.push_back(ps2_data);
                rx_bitcnt++;
                hi_cnt = 0;
                if (rx_bitcnt == 11) begin
                    if (frame[0] !== 1'b0 || frame[10] !== 1'b1 || (^frame[9:1]) !== 1'b1)
                        frame_err++;
                    rx_q.push_back(frame[8:1]);
                    par_q.push_back(frame[9]);
                    rx_bitcnt = 0;
                end
            end else if (ps2_clk) begin
                hi_cnt++;
                if (hi_cnt > int'(2 * HP + 2)) rx_bitcnt = 0;
            end else begin
                hi_cnt = 0;
            end
            prev_clk = ps2_clk;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_rx();
        rx_q.delete();
        par_q.delete();
        bits_q.delete();
        start_q.delete();
    endtask

    task automatic push(input logic [7:0] b);
        in_data  = b;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_rx(input int n, input int budget, input string tag);
        for (int i = 0; i < budget && rx_q.size() < n; i++) @(negedge clk);
        check(tag, (rx_q.size() >= n), 1);
    endtask

    task automatic wait_bits(input int n, input int budget, input string tag);
        for (int i = 0; i < budget && rx_bitcnt != n; i++) @(negedge clk);
        check(tag, (rx_bitcnt == n), 1);
    endtask

    task automatic wait_idle(input int budget, input string tag);
        for (int i = 0; i < budget && busy !== 1'b0; i++) @(negedge clk);
        check(tag, busy, 0);
    endtask

    initial begin
        logic [10:0] exp_bits;
        logic [7:0]  exp_byte;

        // Reset state
        step(3);
        check("rst_clk", ps2_clk, 1);
        check("rst_data", ps2_data, 1);
        check("rst_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_count", fifo_count, 0);
        resetn = 1'b1;
        step(2);
        clear_rx();

        // T1: single byte 0x1C, latency and bit sequence
        push(8'h1C);
        check("t1_count_after_push", fifo_count, 1);
        check("t1_busy", busy, 1);
        check("t1_data_n", ps2_data, 1);
        step(1);
        check("t1_data_n1", ps2_data, 1);
        step(1);
        check("t1_data_n2_start", ps2_data, 0);
        check("t1_clk_n2", ps2_clk, 1);
        step(HP - 1);
        check("t1_clk_before_fall", ps2_clk, 1);
        step(1);
        check("t1_clk_first_fall", ps2_clk, 0);
        wait_rx(1, 200, "t1_rx_timeout");
        check("t1_head_kept_until_stop", fifo_count, 1);
        exp_bits = 11'b100_0011_1000;
        for (int i = 0; i < 11; i++) begin
            check($sformatf("t1_bit%0d", i), (bits_q.size() > i) ? bits_q[i] : 1'bx, exp_bits[i]);
        end
        wait_idle(100, "t1_idle");
        check("t1_count_popped", fifo_count, 0);

        // T2: back-to-back F0, 1C with start-to-start spacing
        step(2);
        clear_rx();
        in_data  = 8'hF0;
        in_valid = 1'b1;
        @(negedge clk);
        in_data  = 8'h1C;
        @(negedge clk);
        in_valid = 1'b0;
        check("t2_count", fifo_count, 2);
        wait_rx(2, 400, "t2_rx_timeout");
        check("t2_byte0", rx_q[0], 8'hF0);
        check("t2_byte1", rx_q[1], 8'h1C);
        check("t2_par0", par_q[0], 1);
        check("t2_par1", par_q[1], 0);
        check("t2_spacing", start_q[1] - start_q[0], 22 * HP + GAP + 1);
        wait_idle(100, "t2_idle");

        // T3: fill under inhibit, then drain in order
        step(2);
        clear_rx();
        host_inhibit = 1'b1;
        step(1);
        for (int i = 0; i < 9; i++) begin
            in_data  = 8'h10 + 8'(i);
            in_valid = 1'b1;
            @(negedge clk);
            if (i == 6) check("t3_ready_at7", in_ready, 1);
            if (i == 7) check("t3_ready_full", in_ready, 0);
        end
        in_valid = 1'b0;
        check("t3_count_full", fifo_count, 8);
        step(40);
        check("t3_clk_high", ps2_clk, 1);
        check("t3_data_high", ps2_data, 1);
        check("t3_no_rx", rx_q.size(), 0);
        host_inhibit = 1'b0;
        wait_rx(8, 1000, "t3_rx_timeout");
        for (int i = 0; i < 8; i++) begin
            exp_byte = 8'h10 + 8'(i);
            check($sformatf("t3_byte%0d", i), (rx_q.size() > i) ? rx_q[i] : 8'hxx, exp_byte);
        end
        wait_idle(150, "t3_idle");
        check("t3_total_frames", rx_q.size(), 8);

        // T4: inhibit during slot 4 of 0x5A, retransmit
        step(2);
        clear_rx();
        push(8'h5A);
        wait_bits(4, 200, "t4_bits_timeout");
        step(2 * HP + 1);
        check("t4_clk_low_slot4", ps2_clk, 0);
        host_inhibit = 1'b1;
        step(1);
        check("t4_abort_clk", ps2_clk, 1);
        check("t4_abort_data", ps2_data, 1);
        check("t4_abort_count", fifo_count, 1);
        step(30);
        check("t4_held_clk", ps2_clk, 1);
        check("t4_no_rx", rx_q.size(), 0);
        host_inhibit = 1'b0;
        wait_rx(1, 300, "t4_rx_timeout");
        check("t4_byte", rx_q[0], 8'h5A);
        wait_idle(100, "t4_idle");
        check("t4_once", rx_q.size(), 1);
        check("t4_count", fifo_count, 0);

        // T5: inhibit during stop slot, frame completes, next waits
        step(2);
        clear_rx();
        in_data  = 8'h33;
        in_valid = 1'b1;
        @(negedge clk);
        in_data  = 8'h44;
        @(negedge clk);
        in_valid = 1'b0;
        wait_bits(10, 200, "t5_bits_timeout");
        step(HP + 2);
        host_inhibit = 1'b1;
        wait_rx(1, 50, "t5_rx_timeout");
        check("t5_byte0", rx_q[0], 8'h33);
        step(40);
        check("t5_count_popped", fifo_count, 1);
        check("t5_clk_high", ps2_clk, 1);
        check("t5_data_high", ps2_data, 1);
        check("t5_waiting", rx_q.size(), 1);
        host_inhibit = 1'b0;
        wait_rx(2, 300, "t5_rx2_timeout");
        check("t5_byte1", rx_q[1], 8'h44);
        wait_idle(100, "t5_idle");

        // T6: async reset mid-frame
        step(2);
        clear_rx();
        push(8'h77);
        wait_bits(6, 200, "t6_bits_timeout");
        step(2 * HP + 1);
        check("t6_clk_low_slot6", ps2_clk, 0);
        resetn = 1'b0;
        #1;
        check("t6_rst_clk", ps2_clk, 1);
        check("t6_rst_data", ps2_data, 1);
        check("t6_rst_count", fifo_count, 0);
        check("t6_rst_busy", busy, 0);
        step(3);
        resetn = 1'b1;
        step(200);
        check("t6_no_stray", rx_q.size(), 0);
        check("t6_idle_busy", busy, 0);
        check("t6_idle_data", ps2_data, 1);

        check("frame_format_errors", frame_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
